// File: rtl/lcd_pkg.sv
// Shared types for the LCD init sequencer: ROM entry layout, opcodes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lcd_pkg;

    localparam int ROM_ENTRY_W = 10;

    typedef enum logic [1:0] {
        OP_CMD   = 2'b00,
        OP_DATA  = 2'b01,
        OP_DELAY = 2'b10,
        OP_END   = 2'b11
    } rom_op_e;

    typedef struct packed {
        rom_op_e    op;
        logic [7:0] arg;
    } rom_entry_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_FINISH
    } seq_state_e;

    function automatic rom_entry_t rom_entry(input rom_op_e op, input logic [7:0] arg);
        rom_entry_t e;
        e.op  = op;
        e.arg = arg;
        return e;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Init-sequence ROM: case-table contents, selectable image, registered read.
// Latency: 1 cycle from addr_i to data_o.
// Backpressure: none; reads every cycle, unused addresses return END.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int ROM_DEPTH = 64,
    parameter int ROM_IMAGE = 0,
    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output rom_entry_t    data_o
);

    rom_entry_t entry_d;
    rom_entry_t data_q;

    // Table lookup. Image 0 is the panel bring-up list; image 1 is a short
    // list with no terminator, used when the ROM depth alone ends the run.
    always_comb begin
        entry_d = rom_entry(OP_END, 8'h00);
        if (ROM_IMAGE == 1) begin
            case (32'(addr_i))
                32'd0:   entry_d = rom_entry(OP_CMD,   8'h11);
                32'd1:   entry_d = rom_entry(OP_DELAY, 8'h00);
                32'd2:   entry_d = rom_entry(OP_DATA,  8'h3C);
                32'd3:   entry_d = rom_entry(OP_CMD,   8'h29);
                default: entry_d = rom_entry(OP_END,   8'h00);
            endcase
        end else begin
            case (32'(addr_i))
                32'd0:   entry_d = rom_entry(OP_CMD,   8'h01);
                32'd1:   entry_d = rom_entry(OP_DELAY, 8'h05);
                32'd2:   entry_d = rom_entry(OP_DATA,  8'hA5);
                32'd3:   entry_d = rom_entry(OP_END,   8'h00);
                default: entry_d = rom_entry(OP_END,   8'h00);
            endcase
        end
    end

    // Synchronous read port.
    always_ff @(posedge clk) begin
        data_q <= entry_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/lcd_init_sequencer.sv
// Walks the init ROM: pulses LCD reset, then issues command/data bytes to an SPI master with delays.
// Latency: reset phase RST_LOW_MS+RST_WAIT_MS ms, then ~3 cycles per entry plus SPI and delay time.
// Backpressure: holds each byte in SEND while spi_busy=1; waits for spi_done before the next entry.
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int CLK_PER_MS  = 16000,
    parameter int RST_LOW_MS  = 10,
    parameter int RST_WAIT_MS = 120,
    parameter int ROM_DEPTH   = 64,
    parameter int ROM_IMAGE   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init_start,
    output logic       init_busy,
    output logic       init_done,
    output logic       lcd_rst_n,
    output logic       spi_start,
    output logic [7:0] spi_data,
    output logic       spi_dc,
    input  logic       spi_busy,
    input  logic       spi_done
);

    localparam int AW     = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int PW     = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MS_MAX = max3(RST_LOW_MS, RST_WAIT_MS, 255);
    localparam int MW     = $clog2(MS_MAX + 1);

    localparam logic [PW-1:0] PRESC_LAST    = PW'(CLK_PER_MS - 1);
    localparam logic [MW-1:0] RST_LOW_LAST  = MW'(RST_LOW_MS - 1);
    localparam logic [MW-1:0] RST_WAIT_LAST = MW'(RST_WAIT_MS - 1);
    localparam logic [AW-1:0] ADDR_LAST     = AW'(ROM_DEPTH - 1);

    seq_state_e    state_q;
    logic [AW-1:0] addr_q;
    logic [PW-1:0] presc_q;
    logic [MW-1:0] ms_q;
    logic [MW-1:0] ms_last_q;
    logic          init_busy_q;
    logic          init_done_q;
    logic          lcd_rst_n_q;
    logic          spi_start_q;
    logic [7:0]    spi_data_q;
    logic          spi_dc_q;

    rom_entry_t    rom_q;
    logic          tick_d;
    logic          expire_d;
    logic          timed_d;
    seq_state_e    adv_state_d;
    logic [AW-1:0] adv_addr_d;

    lcd_init_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .ROM_IMAGE (ROM_IMAGE)
    ) u_rom (
        .clk    (clk),
        .addr_i (addr_q),
        .data_o (rom_q)
    );

    // Timer end-of-phase and "entry finished" next address/state; the last
    // ROM slot ends the run instead of wrapping back to address 0.
    always_comb begin
        tick_d      = (presc_q == PRESC_LAST);
        expire_d    = tick_d && (ms_q == ms_last_q);
        timed_d     = (state_q == ST_RST_LOW) || (state_q == ST_RST_WAIT) || (state_q == ST_DELAY);
        adv_state_d = (addr_q == ADDR_LAST) ? ST_FINISH : ST_FETCH;
        adv_addr_d  = (addr_q == ADDR_LAST) ? addr_q : addr_q + AW'(1);
    end

    // Sequencer FSM with registered outputs and the shared ms timer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            presc_q     <= '0;
            ms_q        <= '0;
            ms_last_q   <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            lcd_rst_n_q <= 1'b1;
            spi_start_q <= 1'b0;
            spi_data_q  <= 8'h00;
            spi_dc_q    <= 1'b0;
        end else begin
            spi_start_q <= 1'b0;
            init_done_q <= 1'b0;

            if (timed_d) begin
                if (expire_d) begin
                    presc_q <= '0;
                    ms_q    <= '0;
                end else if (tick_d) begin
                    presc_q <= '0;
                    ms_q    <= ms_q + MW'(1);
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (init_start) begin
                        state_q     <= ST_RST_LOW;
                        addr_q      <= '0;
                        presc_q     <= '0;
                        ms_q        <= '0;
                        ms_last_q   <= RST_LOW_LAST;
                        init_busy_q <= 1'b1;
                        lcd_rst_n_q <= 1'b0;
                    end
                end
                ST_RST_LOW: begin
                    if (expire_d) begin
                        state_q     <= ST_RST_WAIT;
                        ms_last_q   <= RST_WAIT_LAST;
                        lcd_rst_n_q <= 1'b1;
                    end
                end
                ST_RST_WAIT: begin
                    if (expire_d) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (rom_q.op)
                        OP_CMD, OP_DATA: begin
                            spi_data_q <= rom_q.arg;
                            spi_dc_q   <= (rom_q.op == OP_DATA);
                            state_q    <= ST_SEND;
                        end
                        OP_DELAY: begin
                            if (rom_q.arg != 8'h00) begin
                                presc_q   <= '0;
                                ms_q      <= '0;
                                ms_last_q <= MW'(rom_q.arg) - MW'(1);
                                state_q   <= ST_DELAY;
                            end else begin
                                addr_q  <= adv_addr_d;
                                state_q <= adv_state_d;
                            end
                        end
                        default: begin
                            state_q <= ST_FINISH;
                        end
                    endcase
                end
                ST_SEND: begin
                    if (!spi_busy) begin
                        spi_start_q <= 1'b1;
                        state_q     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_done) begin
                        addr_q  <= adv_addr_d;
                        state_q <= adv_state_d;
                    end
                end
                ST_DELAY: begin
                    if (expire_d) begin
                        addr_q  <= adv_addr_d;
                        state_q <= adv_state_d;
                    end
                end
                ST_FINISH: begin
                    init_done_q <= 1'b1;
                    init_busy_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign init_busy = init_busy_q;
    assign init_done = init_done_q;
    assign lcd_rst_n = lcd_rst_n_q;
    assign spi_start = spi_start_q;
    assign spi_data  = spi_data_q;
    assign spi_dc    = spi_dc_q;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: randomized SPI responder, queue scoreboard, reference ROM walker.
// Latency: n/a.
// Backpressure: SPI busy is randomized and can be held externally.
module tb_lcd_init_sequencer;

    localparam int CPM = 4;
    localparam int RLM = 2;
    localparam int RWM = 3;

    logic       clk = 1'b0;
    logic       reset_n, init_start;
    logic       init_busy, init_done, lcd_rst_n, spi_start, spi_dc;
    logic [7:0] spi_data;
    logic       spi_busy, spi_done;
    logic       busy_m, done_m, hold_busy, spur_done;

    logic       init_start2, spi_busy2, spi_done2;
    logic       init_busy2, init_done2, lcd_rst_n2, spi_start2, spi_dc2;
    logic [7:0] spi_data2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int exp_q[$];
    int start_times[$];
    int done_times[$];
    int done_cnt = 0;
    int cur_byte = 0;
    bit in_flight = 1'b0;
    bit prev_busy = 1'b0;

    int got2[$];
    int done2_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign spi_busy = busy_m | hold_busy;
    assign spi_done = done_m | spur_done;

    lcd_init_sequencer #(
        .CLK_PER_MS (CPM), .RST_LOW_MS (RLM), .RST_WAIT_MS (RWM), .ROM_DEPTH (64), .ROM_IMAGE (0)
    ) dut (
        .clk (clk), .reset_n (reset_n), .init_start (init_start),
        .init_busy (init_busy), .init_done (init_done), .lcd_rst_n (lcd_rst_n),
        .spi_start (spi_start), .spi_data (spi_data), .spi_dc (spi_dc),
        .spi_busy (spi_busy), .spi_done (spi_done)
    );

    lcd_init_sequencer #(
        .CLK_PER_MS (CPM), .RST_LOW_MS (RLM), .RST_WAIT_MS (RWM), .ROM_DEPTH (4), .ROM_IMAGE (1)
    ) dut2 (
        .clk (clk), .reset_n (reset_n), .init_start (init_start2),
        .init_busy (init_busy2), .init_done (init_done2), .lcd_rst_n (lcd_rst_n2),
        .spi_start (spi_start2), .spi_data (spi_data2), .spi_dc (spi_dc2),
        .spi_busy (spi_busy2), .spi_done (spi_done2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    // Reference: walk the ROM image listing the bytes ({dc,data}) that must
    // appear on the SPI side and the ms of delay preceding each byte.
    task automatic model_bytes(input int image, input int depth, output int bytes[$], output int gap_ms[$]);
        int ops[4];
        int args[4];
        int pend;
        int op;
        int arg;
        if (image == 0) begin
            ops = '{0, 2, 1, 3};  args = '{'h01, 5, 'hA5, 0};
        end else begin
            ops = '{0, 2, 1, 0};  args = '{'h11, 0, 'h3C, 'h29};
        end
        bytes.delete();
        gap_ms.delete();
        pend = 0;
        for (int i = 0; i < depth; i++) begin
            op  = (i < 4) ? ops[i] : 3;
            arg = (i < 4) ? args[i] : 0;
            if (op == 3) break;
            if (op == 2) pend += arg;
            else begin
                bytes.push_back(op * 256 + arg);
                gap_ms.push_back(pend);
                pend = 0;
            end
        end
    endtask

    // SPI responder for the main DUT: random busy length, then a done pulse.
    initial begin
        busy_m = 1'b0;
        done_m = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (spi_start && reset_n) begin
                busy_m = 1'b1;
                repeat ($urandom_range(1, 6)) begin @(posedge clk); #2; end
                busy_m = 1'b0;
                done_m = 1'b1;
                @(posedge clk); #2;
                done_m = 1'b0;
            end
        end
    end

    // SPI responder for the depth-4 DUT.
    initial begin
        spi_busy2 = 1'b0;
        spi_done2 = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (spi_start2) begin
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #2; end
                spi_done2 = 1'b1;
                @(posedge clk); #2;
                spi_done2 = 1'b0;
            end
        end
    end

    // Scoreboard monitor for the main DUT.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            in_flight = 1'b0;
        end else begin
            if (in_flight) check("data_stable", {spi_dc, spi_data}, cur_byte);
            if (spi_start) begin
                check("start_while_busy", prev_busy, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_spi_start got=%0h required=none", {spi_dc, spi_data});
                end else begin
                    check("byte", {spi_dc, spi_data}, exp_q.pop_front());
                end
                cur_byte  = {spi_dc, spi_data};
                in_flight = 1'b1;
                start_times.push_back(cyc);
            end else if (in_flight && spi_done) begin
                in_flight = 1'b0;
                done_times.push_back(cyc);
            end
            if (init_done) done_cnt++;
        end
        prev_busy = spi_busy;
    end

    // Collector for the depth-4 DUT.
    always @(negedge clk) begin
        if (reset_n && spi_start2) got2.push_back({spi_dc2, spi_data2});
        if (reset_n && init_done2) done2_cnt++;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  init_busy, 0);
        check({tag, "_done"},  init_done, 0);
        check({tag, "_start"}, spi_start, 0);
        check({tag, "_data"},  spi_data, 8'h00);
        check({tag, "_dc"},    spi_dc, 0);
        check({tag, "_rstn"},  lcd_rst_n, 1);
    endtask

    task automatic start_run();
        int b[$];
        int g[$];
        @(posedge clk); #1;
        model_bytes(0, 64, b, g);
        foreach (b[i]) exp_q.push_back(b[i]);
        init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < limit) begin @(negedge clk); n++; end
        check(name, done_cnt != d0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n, m, k, s0, d0, dc0, t_drop;
        int b[$];
        int g[$];

        reset_n = 1'b0; init_start = 1'b0; hold_busy = 1'b0; spur_done = 1'b0; init_start2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset_n = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);

        // Reset pulse widths, two bytes around a 5 ms delay, single done.
        model_bytes(0, 64, b, g);
        s0 = start_times.size(); d0 = done_times.size(); dc0 = done_cnt;
        start_run();
        @(negedge clk);
        check("busy_rise", init_busy, 1);
        n = 0;
        while (!lcd_rst_n && n < 100) begin n++; @(negedge clk); end
        check("rst_low_cycles", n, RLM * CPM);
        m = 0;
        while (!spi_start && m < 200) begin m++; @(negedge clk); end
        check("rst_wait_min_cycles", (m >= RWM * CPM) && (m < 200), 1);
        wait_done(1000, "run_a_done");
        check("run_a_busy_low", init_busy, 0);
        check("run_a_byte_count", start_times.size() - s0, b.size());
        check("run_a_queue_empty", exp_q.size(), 0);
        if ((start_times.size() - s0 >= 2) && (done_times.size() - d0 >= 1))
            check("run_a_delay_gap", (start_times[s0 + 1] - done_times[d0]) >= g[1] * CPM, 1);
        repeat (20) @(negedge clk);
        check("run_a_done_count", done_cnt - dc0, 1);
        check("run_a_done_low", init_done, 0);

        // spi_busy held through the start of SEND.
        repeat ($urandom_range(2, 10)) @(posedge clk);
        s0 = start_times.size();
        start_run();
        n = 0;
        while (!lcd_rst_n && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 hold_busy = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("hold_no_start", start_times.size() - s0, 0);
        check("hold_data_latched", {spi_dc, spi_data}, b[0]);
        @(posedge clk); #1 hold_busy = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!spi_start && k < 10);
        check("hold_start_after_release", (k >= 1) && (k <= 3) && spi_start, 1);
        wait_done(1000, "hold_done");
        check("hold_queue_empty", exp_q.size(), 0);

        // Second init_start and a stray spi_done during the delay.
        repeat ($urandom_range(2, 10)) @(posedge clk);
        s0 = start_times.size(); d0 = done_times.size(); dc0 = done_cnt;
        start_run();
        n = 0;
        while (done_times.size() == d0 && n < 400) begin @(negedge clk); n++; end
        check("ignore_first_byte", done_times.size() > d0, 1);
        repeat ($urandom_range(3, 8)) @(posedge clk);
        #1 init_start = 1'b1; spur_done = 1'b1;
        @(posedge clk); #1 init_start = 1'b0; spur_done = 1'b0;
        @(negedge clk);
        check("ignore_rstn_high", lcd_rst_n, 1);
        wait_done(1000, "ignore_done");
        check("ignore_byte_count", start_times.size() - s0, b.size());
        check("ignore_queue_empty", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        check("ignore_done_count", done_cnt - dc0, 1);

        // Reset pulse while a byte is in flight.
        repeat ($urandom_range(2, 10)) @(posedge clk);
        start_run();
        m = 0;
        while (!spi_start && m < 300) begin @(negedge clk); m++; end
        check("abort_reached_byte", spi_start, 1);
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        s0 = start_times.size();
        repeat (80) @(negedge clk);
        check("abort_no_start", start_times.size() - s0, 0);
        check("abort_idle_busy", init_busy, 0);

        // Fresh run after the abort.
        s0 = start_times.size();
        start_run();
        wait_done(1000, "rerun_done");
        check("rerun_byte_count", start_times.size() - s0, b.size());
        check("rerun_queue_empty", exp_q.size(), 0);

        // Unterminated depth-4 ROM: runs off the end without wrapping.
        model_bytes(1, 4, b, g);
        @(posedge clk); #1 init_start2 = 1'b1;
        @(posedge clk); #1 init_start2 = 1'b0;
        n = 0;
        while (done2_cnt == 0 && n < 1000) begin @(negedge clk); n++; end
        check("depth4_done", done2_cnt, 1);
        check("depth4_byte_count", got2.size(), b.size());
        foreach (b[i]) if (i < got2.size()) check("depth4_byte", got2[i], b[i]);
        repeat (60) @(negedge clk);
        check("depth4_no_wrap", got2.size(), b.size());
        check("depth4_single_done", done2_cnt, 1);
        check("depth4_idle", init_busy2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_init_sequencer.md
LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

Interface
REQ-001 Parameter CLK_PER_MS, default 16000, clk cycles per millisecond (16 MHz).
REQ-002 Parameter RST_LOW_MS, default 10, ms that lcd_rst_n is held low.
REQ-003 Parameter RST_WAIT_MS, default 120, ms waited after lcd_rst_n is released.
REQ-004 Parameter ROM_DEPTH, default 64, init-ROM entries; address width is $clog2(ROM_DEPTH).
REQ-005 clk  in  1  single clock; one clock domain; reset is synchronous and active-low.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 init_start  in  1  one-cycle request to run the full init sequence.
REQ-008 init_busy  out  1  high from accepted init_start until sequence end.
REQ-009 init_done  out  1  one-cycle pulse when the sequence completes.
REQ-010 lcd_rst_n  out  1  LCD hardware reset, active-low.
REQ-011 spi_start  out  1  one-cycle byte request to spi_controller.
REQ-012 spi_data  out  8  byte to send; stable from spi_start until spi_done.
REQ-013 spi_dc  out  1  0 = command, 1 = data; stable with spi_data.
REQ-014 spi_busy  in  1  spi_controller busy.
REQ-015 spi_done  in  1  spi_controller one-cycle byte-complete pulse.

Function
REQ-016 Each ROM entry SHALL be 10 bits: op[9:8] (00 CMD, 01 DATA, 10 DELAY, 11 END), arg[7:0].
REQ-017 The FSM SHALL have states IDLE, RST_LOW, RST_WAIT, FETCH, DECODE, SEND, WAIT_DONE, DELAY, FINISH.
REQ-018 IDLE: on init_start, go to RST_LOW, clear ROM address, load delay counters; init_busy rises in the next cycle.
REQ-019 RST_LOW: lcd_rst_n = 0 for exactly RST_LOW_MS*CLK_PER_MS cycles, then RST_WAIT.
REQ-020 RST_WAIT: lcd_rst_n = 1 for RST_WAIT_MS*CLK_PER_MS cycles, then FETCH.
REQ-021 FETCH: present the ROM address; synchronous ROM with 1-cycle read latency; go to DECODE.
REQ-022 DECODE, CMD/DATA: latch spi_data = arg and spi_dc = op[0], then SEND.
REQ-023 DECODE, DELAY: arg>0 goes to DELAY for arg*CLK_PER_MS cycles; arg=0 advances the address and returns to FETCH.
REQ-024 DECODE, END: go to FINISH.
REQ-025 SEND: wait while spi_busy=1; when spi_busy=0, assert spi_start for one cycle and go to WAIT_DONE.
REQ-026 WAIT_DONE: on spi_done, advance the address and go to FETCH; spi_start stays 0.
REQ-027 Address at ROM_DEPTH-1 after completing a non-END entry: go to FINISH; the address never wraps.
REQ-028 FINISH: pulse init_done for one cycle, drop init_busy, return to IDLE.
REQ-029 init_start while init_busy=1 SHALL be ignored; init_start in IDLE after a completed sequence SHALL restart from RST_LOW.
REQ-030 spi_done outside WAIT_DONE SHALL be ignored.
REQ-031 Delay counters: a ms prescaler (0..CLK_PER_MS-1) plus a ms counter; no multiplier in RTL.

Reset
REQ-032 While reset_n=0 at a clk edge: state IDLE, address 0, counters 0, init_busy=0, init_done=0, spi_start=0, spi_data=0x00, spi_dc=0, lcd_rst_n=1.
REQ-033 reset_n low in any state, including mid-byte, SHALL abort the sequence within one cycle with no further spi_start.

Structure
REQ-034 Package lcd_pkg SHALL hold the op encoding (enum), the ROM entry width constant and the FSM state enum.
REQ-035 Sub-module lcd_init_rom SHALL hold the ROM contents (case table, synchronous read, parameter ROM_DEPTH).
REQ-036 The sequencer SHALL connect to spi_controller (SPI_DIV=4) at a top level; it SHALL NOT instantiate it.

Verification
REQ-037 Sim parameters CLK_PER_MS=4, RST_LOW_MS=2, RST_WAIT_MS=3.
REQ-038 Scenario 1: init_start -> lcd_rst_n low exactly 8 cycles, high 12 cycles before the first spi_start.
REQ-039 Scenario 2: ROM {CMD 0x01, DELAY 5, DATA 0xA5, END} -> bytes 0x01/dc=0 and 0xA5/dc=1; gap of at least 20 cycles; one init_done pulse.
REQ-040 Scenario 3: spi_busy held 1 for 6 cycles in SEND -> spi_start issued only after spi_busy falls; spi_data stable throughout.
REQ-041 Scenario 4: second init_start mid-sequence, plus spurious spi_done in DELAY -> both ignored; byte order and count unchanged.
REQ-042 Scenario 5: reset_n low for 1 cycle during WAIT_DONE -> all outputs at reset values next cycle; no spi_start until a new init_start.
REQ-043 Scenario 6: ROM without END, depth 4 -> exactly 4 entries processed, then init_done; the address does not wrap.
